// File: rtl/pipe_pkg.sv
// pipe_pkg: shared lane control layout, kill value and default geometry for pipeline stages.
package pipe_pkg;
  localparam int DEF_LANES = 2;
  localparam int DEF_DATA_W = 96;
  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       memToReg;
    logic       branch;
    logic       aluSrc;
    logic [2:0] aluControl;
    logic [1:0] immSrc;
    logic [1:0] resultSrc;
  } lane_ctrl_t;
  localparam int CTRL_BITS = $bits(lane_ctrl_t);
  localparam lane_ctrl_t CTRL_RST = '0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones and freezes while hold is high.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (inc && !hold && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_lane_stage.sv
// pipe_lane_stage: multi-lane pipeline register with skid buffer, per-lane flush, global hold
// and saturating stall/flush event counters.
module pipe_lane_stage import pipe_pkg::*; #(
  parameter int LANES = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = CTRL_BITS,
  parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(pipe_pkg::CTRL_RST),
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_lane_valid,
  input  logic [LANES*DATA_W-1:0]  in_data,
  input  logic [LANES*CTRL_W-1:0]  in_ctrl,
  input  logic [LANES-1:0]         flush_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         out_lane_valid,
  output logic [LANES*DATA_W-1:0]  out_data,
  output logic [LANES*CTRL_W-1:0]  out_ctrl,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);
  localparam int DW = LANES*DATA_W;
  localparam int CW = LANES*CTRL_W;
  logic mainValid, skidValid, accept, drain, mainKeep;
  logic [LANES-1:0] mainLv, skidLv, pendFlush, effMask;
  logic [DW-1:0] mainData, skidData;
  logic [CW-1:0] mainCtrl, skidCtrl;
  logic [2:0][LANES-1:0] srcLv, kLv;
  logic [2:0][DW-1:0] srcData, kData;
  logic [2:0][CW-1:0] srcCtrl, kCtrl;
  assign in_ready = !hold && !skidValid;
  assign out_valid = mainValid && !hold;
  assign out_lane_valid = mainLv;
  assign out_data = mainData;
  assign out_ctrl = mainCtrl;
  assign accept = in_valid && in_ready;
  assign drain = out_valid && out_ready;
  assign effMask = flush_mask | pendFlush;
  // kill view of each source: 0 = main, 1 = skid, 2 = incoming beat
  assign srcLv = {in_lane_valid, skidLv, mainLv};
  assign srcData = {in_data, skidData, mainData};
  assign srcCtrl = {in_ctrl, skidCtrl, mainCtrl};
  for (genvar s = 0; s < 3; s++) begin : g_src
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign kLv[s][i] = srcLv[s][i] & ~effMask[i];
      assign kData[s][i*DATA_W +: DATA_W] = effMask[i] ? '0 : srcData[s][i*DATA_W +: DATA_W];
      assign kCtrl[s][i*CTRL_W +: CTRL_W] = effMask[i] ? CTRL_RST : srcCtrl[s][i*CTRL_W +: CTRL_W];
    end
  end
  // a main entry survives the edge only if it is not leaving and keeps a live lane
  assign mainKeep = mainValid && !drain && |kLv[0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mainValid <= 1'b0;
      mainLv <= '0;
      mainData <= '0;
      mainCtrl <= {LANES{CTRL_RST}};
      skidValid <= 1'b0;
      skidLv <= '0;
      skidData <= '0;
      skidCtrl <= {LANES{CTRL_RST}};
      pendFlush <= '0;
    end else if (hold) begin
      pendFlush <= pendFlush | flush_mask;
    end else begin
      pendFlush <= '0;
      if (mainKeep) begin
        mainLv <= kLv[0];
        mainData <= kData[0];
        mainCtrl <= kCtrl[0];
        skidValid <= skidValid ? |kLv[1] : accept && |kLv[2];
        skidLv <= skidValid ? kLv[1] : (accept ? kLv[2] : '0);
        skidData <= skidValid ? kData[1] : kData[2];
        skidCtrl <= skidValid ? kCtrl[1] : kCtrl[2];
      end else if (skidValid) begin
        mainValid <= |kLv[1];
        mainLv <= kLv[1];
        mainData <= kData[1];
        mainCtrl <= kCtrl[1];
        skidValid <= 1'b0;
        skidLv <= '0;
      end else begin
        mainValid <= accept && |kLv[2];
        mainLv <= accept ? kLv[2] : '0;
        mainData <= kData[2];
        mainCtrl <= kCtrl[2];
      end
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(clk), .reset(reset), .inc(out_valid && !out_ready), .hold(hold), .cnt(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush (
    .clk(clk), .reset(reset), .inc(|effMask), .hold(hold), .cnt(flush_cnt)
  );
endmodule

// File: tb/tb_pipe_lane_stage.sv
// tb_pipe_lane_stage: directed stimulus with an expected-beat queue checked by an output monitor.
module tb_pipe_lane_stage;
  localparam int L = 2;
  localparam int DW = 96;
  localparam int CW = 12;
  typedef struct {
    logic [L-1:0] lv;
    logic [L*DW-1:0] d;
    logic [L*CW-1:0] c;
  } exp_t;
  logic clk = 0, reset, hold, in_valid, in_ready, out_valid, out_ready;
  logic [L-1:0] in_lane_valid, flush_mask, out_lane_valid;
  logic [L*DW-1:0] in_data, out_data;
  logic [L*CW-1:0] in_ctrl, out_ctrl;
  logic [15:0] stall_cnt, flush_cnt;
  logic in_ready4, out_valid4;
  logic [L-1:0] out_lane_valid4;
  logic [L*DW-1:0] out_data4;
  logic [L*CW-1:0] out_ctrl4;
  logic [3:0] stall_cnt4, flush_cnt4;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipe_lane_stage dut (
    .clk(clk), .reset(reset), .hold(hold), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_data(in_data), .in_ctrl(in_ctrl), .flush_mask(flush_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
    .out_data(out_data), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  pipe_lane_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .hold(hold), .in_valid(in_valid), .in_ready(in_ready4),
    .in_lane_valid(in_lane_valid), .in_data(in_data), .in_ctrl(in_ctrl), .flush_mask(flush_mask),
    .out_valid(out_valid4), .out_ready(out_ready), .out_lane_valid(out_lane_valid4),
    .out_data(out_data4), .out_ctrl(out_ctrl4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );
  function automatic logic [L*DW-1:0] mkData(int tag, logic [L-1:0] kill);
    logic [L*DW-1:0] d;
    for (int l = 0; l < L; l++)
      d[l*DW +: DW] = kill[l] ? '0 : {32'hC0DE0000 | 32'(tag), 32'(tag*7 + l), 32'(l + 1)};
    return d;
  endfunction
  function automatic logic [L*CW-1:0] mkCtrl(int tag, logic [L-1:0] kill);
    logic [L*CW-1:0] c;
    for (int l = 0; l < L; l++)
      c[l*CW +: CW] = kill[l] ? '0 : CW'(tag*3 + l + 1);
    return c;
  endfunction
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(int tag, logic [L-1:0] lv, logic [L-1:0] kill);
    in_valid = 1;
    in_lane_valid = lv;
    in_data = mkData(tag, '0);
    in_ctrl = mkCtrl(tag, '0);
    q.push_back('{lv: lv & ~kill, d: mkData(tag, kill), c: mkCtrl(tag, kill)});
  endtask
  always @(negedge clk)
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL beat unexpected beat lv %b ctrl %h", out_lane_valid, out_ctrl);
      end else begin
        e = q.pop_front();
        if (out_lane_valid !== e.lv || out_data !== e.d || out_ctrl !== e.c) begin
          errors++;
          $display("FAIL beat got lv %b ctrl %h data %h want lv %b ctrl %h data %h",
                   out_lane_valid, out_ctrl, out_data, e.lv, e.c, e.d);
        end
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 0; hold = 0; in_valid = 0; in_lane_valid = '0; in_data = '0; in_ctrl = '0;
    flush_mask = '0; out_ready = 0;
    #1 reset = 1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_lane_valid", 64'(out_lane_valid), 0);
    chk("rst_data_zero", 64'(out_data == '0), 1);
    chk("rst_ctrl", 64'(out_ctrl), 0);
    chk("rst_cnts", {32'(stall_cnt), 32'(flush_cnt)}, 0);
    tick();
    reset = 0;
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      offer(k + 1, (k % 3 == 1) ? 2'b01 : (k % 3 == 2) ? 2'b10 : 2'b11, 2'b00);
      chk("t1_in_ready", 64'(in_ready), 1);
      tick();
      chk("t1_out_valid", 64'(out_valid), 1);
    end
    in_valid = 0;
    tick();
    tick();
    chk("t1_queue_empty", 64'(q.size()), 0);
    chk("t1_stall_cnt", 64'(stall_cnt), 0);
    offer(10, 2'b11, 2'b00);
    tick();
    out_ready = 0;
    offer(11, 2'b11, 2'b00);
    chk("t2_in_ready_c1", 64'(in_ready), 1);
    tick();
    chk("t2_stall_c1", 64'(stall_cnt), 1);
    offer(12, 2'b10, 2'b00);
    chk("t2_in_ready_c2", 64'(in_ready), 0);
    tick();
    chk("t2_in_ready_c3", 64'(in_ready), 0);
    tick();
    chk("t2_stall_cnt", 64'(stall_cnt), 3);
    out_ready = 1;
    tick();
    chk("t2_in_ready_rel", 64'(in_ready), 1);
    tick();
    in_valid = 0;
    tick();
    tick();
    chk("t2_queue_empty", 64'(q.size()), 0);
    chk("t2_stall_after", 64'(stall_cnt), 3);
    out_ready = 0;
    offer(20, 2'b11, 2'b10);
    tick();
    in_valid = 0;
    flush_mask = 2'b10;
    tick();
    flush_mask = 2'b00;
    chk("t3_lane_valid", 64'(out_lane_valid), 2'b01);
    chk("t3_lane1_data", 64'(out_data[DW +: DW] == '0), 1);
    chk("t3_lane1_ctrl", 64'(out_ctrl[CW +: CW]), 0);
    chk("t3_lane0_ctrl", 64'(out_ctrl[CW-1:0]), 61);
    chk("t3_flush_cnt", 64'(flush_cnt), 1);
    out_ready = 1;
    tick();
    chk("t3_queue_empty", 64'(q.size()), 0);
    out_ready = 0;
    in_valid = 1;
    in_lane_valid = 2'b01;
    in_data = mkData(30, '0);
    in_ctrl = mkCtrl(30, '0);
    tick();
    in_valid = 0;
    hold = 1;
    flush_mask = 2'b01;
    tick();
    flush_mask = 2'b00;
    tick();
    chk("t4_hold_out_valid", 64'(out_valid), 0);
    chk("t4_hold_in_ready", 64'(in_ready), 0);
    chk("t4_hold_lane_valid", 64'(out_lane_valid), 2'b01);
    chk("t4_hold_ctrl", 64'(out_ctrl[CW-1:0]), 91);
    chk("t4_hold_flush_cnt", 64'(flush_cnt), 1);
    hold = 0;
    tick();
    chk("t4_dropped", 64'(out_valid), 0);
    chk("t4_lane_valid", 64'(out_lane_valid), 0);
    chk("t4_flush_cnt", 64'(flush_cnt), 2);
    offer(40, 2'b11, 2'b00);
    tick();
    offer(41, 2'b01, 2'b00);
    tick();
    in_valid = 0;
    chk("t5_full_in_ready", 64'(in_ready), 0);
    #2 reset = 1;
    #1;
    q.delete();
    chk("t5_out_valid", 64'(out_valid), 0);
    chk("t5_in_ready", 64'(in_ready), 1);
    chk("t5_cnts", {32'(stall_cnt), 32'(flush_cnt)}, 0);
    chk("t5_cnts4", {32'(stall_cnt4), 32'(flush_cnt4)}, 0);
    tick();
    reset = 0;
    offer(50, 2'b11, 2'b00);
    tick();
    in_valid = 0;
    repeat (15) tick();
    chk("t6_sat_reach", 64'(stall_cnt4), 15);
    chk("t6_wide_15", 64'(stall_cnt), 15);
    repeat (5) tick();
    chk("t6_sat_stay", 64'(stall_cnt4), 15);
    chk("t6_wide_20", 64'(stall_cnt), 20);
    out_ready = 1;
    tick();
    tick();
    chk("final_queue_empty", 64'(q.size()), 0);
    chk("final_out_valid", 64'(out_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
